// File: rtl/bk_sram_pkg.sv
// Shared types and helpers for the SRAM slot arbiter: FSM states, strobe bundle,
// byte-lane encoding and CPU byte-address to SRAM word-address conversion.
package bk_sram_pkg;

  localparam int         AW_DEFAULT         = 18;
  localparam int         DW_DEFAULT         = 16;
  localparam logic [3:0] VIDEO_SLOT_DEFAULT = 4'd0;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    REPLY,
    RELEASE,
    DBG
  } state_e;

  typedef struct packed {
    logic oe_n;
    logic we_n;
    logic lb_n;
    logic ub_n;
    logic wdata_oe;
  } strobe_t;

  localparam strobe_t STROBE_IDLE  = '{oe_n: 1'b1, we_n: 1'b1, lb_n: 1'b1, ub_n: 1'b1, wdata_oe: 1'b0};
  localparam strobe_t STROBE_VIDEO = '{oe_n: 1'b0, we_n: 1'b1, lb_n: 1'b0, ub_n: 1'b0, wdata_oe: 1'b0};

  typedef struct packed {
    logic lb_n;
    logic ub_n;
  } lanes_t;

  // A byte access enables only the lane selected by address bit 0; words enable both.
  function automatic lanes_t byte_lanes(input logic byte_acc, input logic odd);
    lanes_t l;
    l.lb_n = byte_acc & odd;
    l.ub_n = byte_acc & ~odd;
    return l;
  endfunction

  function automatic logic [14:0] ram_word_addr(input logic [15:0] cpu_adr);
    return 15'(cpu_adr >> 1);
  endfunction

endpackage

// File: rtl/sram_bus_mux.sv
// Final SRAM pin mux: the video slot overrides whichever master the FSM has
// handed the bus to (debug host while granted, otherwise the CPU access path).
module sram_bus_mux
  import bk_sram_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          video_slot,
  input  logic [AW-1:0] vid_addr,
  input  logic [AW-1:0] fsm_addr,
  input  logic [DW-1:0] fsm_wdata,
  input  strobe_t       fsm_strobe,
  input  logic          dbg_own,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  strobe_t       dbg_strobe,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output strobe_t       strobe,
  output logic          vid_load
);

  // NOTE: every output gets a value before any branch, so no latch can be inferred.
  always_comb begin
    ram_addr  = fsm_addr;
    ram_wdata = fsm_wdata;
    strobe    = fsm_strobe;
    if (dbg_own) begin
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
      strobe    = dbg_strobe;
    end
    if (video_slot) begin
      ram_addr = vid_addr;
      strobe   = STROBE_VIDEO;
    end
  end

  assign vid_load = video_slot;

endmodule

// File: rtl/sram_slot_arbiter.sv
// Time-slot arbiter for the shared SRAM (video / CPU / debug host).
// Define SRAM_ARB_DBG_EN to enable the debug hold/grant path; otherwise it is inert.
module sram_slot_arbiter
  import bk_sram_pkg::*;
#(
  parameter int         AW         = AW_DEFAULT,
  parameter int         DW         = DW_DEFAULT,
  parameter logic [3:0] VIDEO_SLOT = VIDEO_SLOT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [3:0]    phase_i,
  input  logic [AW-1:0] vid_addr_i,
  output logic          vid_load_o,
  input  logic          cpu_rd_i,
  input  logic          cpu_wt_i,
  input  logic [15:0]   cpu_adr_i,
  input  logic          cpu_byte_i,
  input  logic [DW-1:0] cpu_data_i,
  output logic [DW-1:0] cpu_data_o,
  output logic          cpu_reply_o,
  input  logic          dbg_req_i,
  output logic          dbg_gnt_o,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic          dbg_oe_n_i,
  input  logic          dbg_we_n_i,
  input  logic [DW-1:0] dbg_data_i,
  output logic [DW-1:0] dbg_data_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic          ram_wdata_oe_o,
  input  logic [DW-1:0] ram_data_i,
  output logic          ram_oe_n_o,
  output logic          ram_we_n_o,
  output logic          ram_lb_n_o,
  output logic          ram_ub_n_o
);

  state_e        state, state_next;
  strobe_t       acc_strobe, dbg_strobe, bus_strobe;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [3:0]    phase_next;
  logic          cpu_req, slot_ok, video_slot;
  logic          dbg_req, gnt;
  lanes_t        lanes;

  assign phase_next = phase_i + 4'd1;
  assign video_slot = (phase_i == VIDEO_SLOT);
  // An access started now occupies the next phase, which must not be the video slot.
  assign slot_ok    = (phase_next != VIDEO_SLOT);
  assign cpu_req    = cpu_rd_i | cpu_wt_i;
  assign lanes      = byte_lanes(cpu_byte_i, cpu_adr_i[0]);

`ifdef SRAM_ARB_DBG_EN
  assign dbg_req    = dbg_req_i;
  assign dbg_strobe = '{oe_n: dbg_oe_n_i, we_n: dbg_we_n_i, lb_n: 1'b0, ub_n: 1'b0,
                        wdata_oe: ~dbg_we_n_i};

  always_ff @(posedge clk) begin
    if (!reset_n) gnt <= 1'b0;
    else          gnt <= (state == DBG) && dbg_req_i;
  end

  assign dbg_data_o = gnt ? ram_data_i : '0;
`else
  logic dbg_unused;
  assign dbg_unused = dbg_req_i ^ dbg_oe_n_i ^ dbg_we_n_i;
  assign dbg_req    = 1'b0;
  assign dbg_strobe = STROBE_IDLE;
  assign gnt        = 1'b0;
  assign dbg_data_o = '0;
`endif

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          if (slot_ok) state_next = ACCESS;
        end else if (dbg_req) begin
          state_next = DBG;
        end
      end
      ACCESS:  state_next = REPLY;
      REPLY:   state_next = RELEASE;
      RELEASE: if (!cpu_req) state_next = IDLE;
      DBG:     if (!dbg_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_reply_o = (state == REPLY);
    dbg_gnt_o   = gnt;
  end

  // Strobes for the ACCESS cycle are captured on entry; a simultaneous rd+wt is a write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_strobe <= STROBE_IDLE;
      acc_addr   <= '0;
      acc_wdata  <= '0;
    end else if (state_next == ACCESS) begin
      acc_strobe.oe_n     <= ~(cpu_rd_i & ~cpu_wt_i);
      acc_strobe.we_n     <= ~cpu_wt_i;
      acc_strobe.wdata_oe <= cpu_wt_i;
      acc_strobe.lb_n     <= lanes.lb_n;
      acc_strobe.ub_n     <= lanes.ub_n;
      acc_addr            <= AW'(ram_word_addr(cpu_adr_i));
      acc_wdata           <= cpu_data_i;
    end else begin
      acc_strobe <= STROBE_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                                  cpu_data_o <= '0;
    else if (state == ACCESS && !acc_strobe.oe_n)  cpu_data_o <= ram_data_i;
  end

  sram_bus_mux #(.AW(AW), .DW(DW)) u_mux (
    .video_slot (video_slot),
    .vid_addr   (vid_addr_i),
    .fsm_addr   (acc_addr),
    .fsm_wdata  (acc_wdata),
    .fsm_strobe (acc_strobe),
    .dbg_own    (gnt),
    .dbg_addr   (dbg_addr_i),
    .dbg_wdata  (dbg_data_i),
    .dbg_strobe (dbg_strobe),
    .ram_addr   (ram_addr_o),
    .ram_wdata  (ram_wdata_o),
    .strobe     (bus_strobe),
    .vid_load   (vid_load_o)
  );

  assign ram_oe_n_o     = bus_strobe.oe_n;
  assign ram_we_n_o     = bus_strobe.we_n;
  assign ram_lb_n_o     = bus_strobe.lb_n;
  assign ram_ub_n_o     = bus_strobe.ub_n;
  assign ram_wdata_oe_o = bus_strobe.wdata_oe;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Directed bench for sram_slot_arbiter with a small behavioural SRAM model.
module tb_sram_slot_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  phase_i;
  logic [17:0] vid_addr_i;
  logic        vid_load_o;
  logic        cpu_rd_i, cpu_wt_i, cpu_byte_i;
  logic [15:0] cpu_adr_i, cpu_data_i, cpu_data_o;
  logic        cpu_reply_o;
  logic        dbg_req_i, dbg_gnt_o, dbg_oe_n_i, dbg_we_n_i;
  logic [17:0] dbg_addr_i;
  logic [15:0] dbg_data_i, dbg_data_o;
  logic [17:0] ram_addr_o;
  logic [15:0] ram_wdata_o, ram_data_i;
  logic        ram_wdata_oe_o, ram_oe_n_o, ram_we_n_o, ram_lb_n_o, ram_ub_n_o;

  logic [15:0] mem [0:255];
  int          errors = 0;
  int          checks = 0;
  int          reply_cnt, oe_cnt;

  localparam logic [17:0] VID_ADDR = 18'h2_0055;

  always #5 clk = ~clk;

  sram_slot_arbiter dut (
    .clk(clk), .reset_n(reset_n), .phase_i(phase_i), .vid_addr_i(vid_addr_i),
    .vid_load_o(vid_load_o), .cpu_rd_i(cpu_rd_i), .cpu_wt_i(cpu_wt_i),
    .cpu_adr_i(cpu_adr_i), .cpu_byte_i(cpu_byte_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_reply_o(cpu_reply_o), .dbg_req_i(dbg_req_i),
    .dbg_gnt_o(dbg_gnt_o), .dbg_addr_i(dbg_addr_i), .dbg_oe_n_i(dbg_oe_n_i),
    .dbg_we_n_i(dbg_we_n_i), .dbg_data_i(dbg_data_i), .dbg_data_o(dbg_data_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_wdata_oe_o(ram_wdata_oe_o),
    .ram_data_i(ram_data_i), .ram_oe_n_o(ram_oe_n_o), .ram_we_n_o(ram_we_n_o),
    .ram_lb_n_o(ram_lb_n_o), .ram_ub_n_o(ram_ub_n_o)
  );

  // SRAM model: 256 words, asynchronous read, byte-lane write on the clock edge.
  assign ram_data_i = mem[ram_addr_o[7:0]];

  always @(posedge clk) begin
    if (!ram_we_n_o) begin
      if (!ram_lb_n_o) mem[ram_addr_o[7:0]][7:0]  <= ram_wdata_o[7:0];
      if (!ram_ub_n_o) mem[ram_addr_o[7:0]][15:8] <= ram_wdata_o[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; phase moves on and combinational outputs have settled on return.
  task automatic step();
    @(posedge clk);
    #1;
    phase_i = phase_i + 4'd1;
    #1;
  endtask

  task automatic goto_phase(input logic [3:0] p);
    int n = 0;
    while (phase_i != p && n < 20) begin
      step();
      n++;
    end
    if (phase_i != p) check("goto_phase_timeout", {28'd0, phase_i}, {28'd0, p});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1234;
    mem[8'h55] = 16'hBEEF;
    mem[8'h10] = 16'h0F0F;
    reset_n = 1'b0; phase_i = 4'd0; vid_addr_i = VID_ADDR;
    cpu_rd_i = 1'b0; cpu_wt_i = 1'b0; cpu_byte_i = 1'b0; cpu_adr_i = '0; cpu_data_i = '0;
    dbg_req_i = 1'b0; dbg_addr_i = '0; dbg_oe_n_i = 1'b1; dbg_we_n_i = 1'b1; dbg_data_i = '0;

    // Reset state, away from the video slot
    step(); step();
    check("rst_oe_n", ram_oe_n_o, 1);
    check("rst_we_n", ram_we_n_o, 1);
    check("rst_lb_ub", {ram_lb_n_o, ram_ub_n_o}, 2'b11);
    check("rst_wdata_oe", ram_wdata_oe_o, 0);
    check("rst_reply", cpu_reply_o, 0);
    check("rst_gnt", dbg_gnt_o, 0);
    check("rst_cpu_data", cpu_data_o, 16'h0000);
    check("rst_vid_load_off", vid_load_o, 0);
    goto_phase(4'd0);
    check("rst_slot_vid_load", vid_load_o, 1);
    check("rst_slot_addr", ram_addr_o, VID_ADDR);
    reset_n = 1'b1;

    // Word read 0o1000 issued at phase 3
    goto_phase(4'd3);
    cpu_rd_i = 1'b1; cpu_adr_i = 16'o1000; cpu_byte_i = 1'b0;
    check("rd_idle_oe_n", ram_oe_n_o, 1);
    step();
    check("rd_acc_oe_n", ram_oe_n_o, 0);
    check("rd_acc_we_n", ram_we_n_o, 1);
    check("rd_acc_addr", ram_addr_o, 18'h00100);
    check("rd_acc_lanes", {ram_lb_n_o, ram_ub_n_o}, 2'b00);
    check("rd_acc_no_reply", cpu_reply_o, 0);
    step();
    check("rd_reply_ph5", cpu_reply_o, 1);
    check("rd_data", cpu_data_o, 16'h1234);
    check("rd_reply_oe_n", ram_oe_n_o, 1);
    cpu_rd_i = 1'b0;
    step();
    check("rd_reply_single", cpu_reply_o, 0);

    // Byte write 0o1001 arriving in the last phase before the slot waits through it
    goto_phase(4'd15);
    cpu_wt_i = 1'b1; cpu_adr_i = 16'o1001; cpu_byte_i = 1'b1; cpu_data_i = 16'hAB00;
    check("wr_ph15_we_n", ram_we_n_o, 1);
    step();
    check("wr_slot_vid_load", vid_load_o, 1);
    check("wr_slot_addr", ram_addr_o, VID_ADDR);
    check("wr_slot_we_n", ram_we_n_o, 1);
    check("wr_slot_wdata_oe", ram_wdata_oe_o, 0);
    step();
    check("wr_ph1_we_n", ram_we_n_o, 0);
    check("wr_ph1_lanes", {ram_lb_n_o, ram_ub_n_o}, 2'b10);
    check("wr_ph1_wdata_oe", ram_wdata_oe_o, 1);
    check("wr_ph1_wdata", ram_wdata_o, 16'hAB00);
    check("wr_ph1_addr", ram_addr_o, 18'h00100);
    step();
    check("wr_reply_ph2", cpu_reply_o, 1);
    check("wr_mem", mem[8'h00], 16'hAB34);
    cpu_wt_i = 1'b0; cpu_byte_i = 1'b0;
    step();

    // Read held for many cycles after its reply: one reply, one oe_n pulse
    goto_phase(4'd5);
    cpu_rd_i = 1'b1; cpu_adr_i = 16'o1000;
    reply_cnt = 0; oe_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (cpu_reply_o) reply_cnt++;
      if (phase_i != 4'd0 && !ram_oe_n_o) oe_cnt++;
      if (phase_i == 4'd0) begin
        check("hold_slot_vid_load", vid_load_o, 1);
        check("hold_slot_addr", ram_addr_o, VID_ADDR);
      end
    end
    check("hold_reply_count", reply_cnt, 1);
    check("hold_oe_count", oe_cnt, 1);
    check("hold_data", cpu_data_o, 16'hAB34);
    cpu_rd_i = 1'b0;
    step();

    // Reset asserted during ACCESS abandons the cycle
    goto_phase(4'd8);
    cpu_rd_i = 1'b1;
    step();
    check("rstacc_oe_n", ram_oe_n_o, 0);
    reset_n = 1'b0;
    step();
    check("rstacc_oe_n_after", ram_oe_n_o, 1);
    check("rstacc_reply", cpu_reply_o, 0);
    check("rstacc_gnt", dbg_gnt_o, 0);
    check("rstacc_data", cpu_data_o, 16'h0000);
    cpu_rd_i = 1'b0; reset_n = 1'b1;
    step();
    check("rstacc_no_late_reply", cpu_reply_o, 0);

`ifdef SRAM_ARB_DBG_EN
    // Debug request while a CPU read is pending: CPU completes first
    goto_phase(4'd3);
    cpu_rd_i = 1'b1; dbg_req_i = 1'b1;
    step();
    check("dbg_acc_gnt", dbg_gnt_o, 0);
    step();
    check("dbg_cpu_reply", cpu_reply_o, 1);
    cpu_rd_i = 1'b0;
    step();
    check("dbg_release_gnt", dbg_gnt_o, 0);
    step();
    check("dbg_idle_gnt", dbg_gnt_o, 0);
    step();
    check("dbg_entry_gnt", dbg_gnt_o, 0);
    step();
    check("dbg_gnt_rise", dbg_gnt_o, 1);
    dbg_addr_i = 18'h00010; dbg_oe_n_i = 1'b0;
    #1;
    check("dbg_rd_addr", ram_addr_o, 18'h00010);
    check("dbg_rd_oe_n", ram_oe_n_o, 0);
    check("dbg_rd_data", dbg_data_o, 16'h0F0F);
    step();
    dbg_oe_n_i = 1'b1; dbg_we_n_i = 1'b0; dbg_data_i = 16'h5A5A; cpu_rd_i = 1'b1;
    #1;
    check("dbg_wr_we_n", ram_we_n_o, 0);
    check("dbg_wr_wdata_oe", ram_wdata_oe_o, 1);
    goto_phase(4'd0);
    check("dbg_slot_we_masked", ram_we_n_o, 1);
    check("dbg_slot_addr", ram_addr_o, VID_ADDR);
    check("dbg_slot_vid_load", vid_load_o, 1);
    check("dbg_cpu_stalled", cpu_reply_o, 0);
    step();
    check("dbg_ph1_we_n", ram_we_n_o, 0);
    check("dbg_ph1_gnt", dbg_gnt_o, 1);
    dbg_we_n_i = 1'b1; dbg_req_i = 1'b0;
    step();
    check("dbg_gnt_drop", dbg_gnt_o, 0);
    check("dbg_mem", mem[8'h10], 16'h5A5A);
    step(); step();
    check("dbg_stalled_reply", cpu_reply_o, 1);
    check("dbg_stalled_data", cpu_data_o, 16'hAB34);
    cpu_rd_i = 1'b0;
    step();
`else
    // Debug path disabled: requests are ignored, CPU reads unaffected
    dbg_req_i = 1'b1;
    goto_phase(4'd3);
    cpu_rd_i = 1'b1; cpu_adr_i = 16'o1000;
    check("nodbg_gnt_idle", dbg_gnt_o, 0);
    step();
    check("nodbg_gnt_acc", dbg_gnt_o, 0);
    check("nodbg_oe_n", ram_oe_n_o, 0);
    step();
    check("nodbg_reply", cpu_reply_o, 1);
    check("nodbg_data", cpu_data_o, 16'hAB34);
    check("nodbg_dbg_data", dbg_data_o, 16'h0000);
    cpu_rd_i = 1'b0;
    step(); step(); step();
    check("nodbg_gnt_late", dbg_gnt_o, 0);
    dbg_req_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
